// File: rtl/home_pkg.sv
// Shared definitions for the home-automation datapath: display codes and actuator bus layout.
// No logic of its own; pure constants and a code-validity helper.
// Not applicable: no flow control.
package home_pkg;

    // Event codes carried on the 3-bit display bus
    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_FDOOR = 3'd1;
    localparam logic [2:0] D_RDOOR = 3'd2;
    localparam logic [2:0] D_FIRE  = 3'd3;
    localparam logic [2:0] D_WIN   = 3'd4;
    localparam logic [2:0] D_HEAT  = 3'd5;
    localparam logic [2:0] D_COOL  = 3'd6;

    // Bit positions in the 6-bit {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler} bus
    localparam int unsigned ACT_W   = 6;
    localparam int unsigned A_FDOOR = 5;
    localparam int unsigned A_RDOOR = 4;
    localparam int unsigned A_ALARM = 3;
    localparam int unsigned A_WIN   = 2;
    localparam int unsigned A_HEAT  = 1;
    localparam int unsigned A_COOL  = 0;

    // Codes 1..6 name a real event; 0 is idle and 7 is garbage from upstream
    function automatic logic disp_valid(input logic [2:0] code);
        return (code >= D_FDOOR) && (code <= D_COOL);
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Pulse stretcher: holds level high for HOLD cycles after the last trig, clr kills the hold.
// Latency 1 cycle from trig to level; clr wins over trig in the same cycle.
// No backpressure: trig is sampled every cycle and always retriggers.
module hold_counter #(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic clr,
    output logic level
);

    localparam int unsigned CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LOAD = CW'(HOLD);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear beats load, load beats decrement, idle stays at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (trig) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign level = (cnt_q != '0);

endmodule

// File: rtl/actuator_hold.sv
// Turns sequencer flicker pulses into held actuator levels, a beeping alarm and a held display code.
// Latency 1 cycle input-to-output; all outputs come from registers (alarm is an AND of two flops).
// No backpressure: inputs are sampled every cycle, heater/cooler interlock resolves in-cycle.
import home_pkg::*;

module actuator_hold #(
    parameter int unsigned HOLD_CYC = 10,
    parameter int unsigned DISP_CYC = 20,
    parameter int unsigned BEEP_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       fdoor,
    input  logic       rdoor,
    input  logic       winbuzz,
    input  logic       alarmbuzz,
    input  logic       heater,
    input  logic       cooler,
    input  logic [2:0] display,
    output logic       fdoor_o,
    output logic       rdoor_o,
    output logic       winbuzz_o,
    output logic       heater_o,
    output logic       cooler_o,
    output logic       alarm_o,
    output logic [2:0] disp_o
);

    localparam int unsigned DW = $clog2(DISP_CYC + 1);
    localparam int unsigned BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_DIV - 1);

    logic [ACT_W-1:0] act_trig;
    logic [ACT_W-1:0] act_clr;
    logic [ACT_W-1:0] act_lvl;
    logic             alarm_lvl;

    assign act_trig = {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler};

    // Interlock: each of heater/cooler kills the other's hold; both together kill both
    always_comb begin
        act_clr         = '0;
        act_clr[A_HEAT] = cooler;
        act_clr[A_COOL] = heater;
    end

    for (genvar i = 0; i < ACT_W; i++) begin : g_hold
        hold_counter #(
            .HOLD (HOLD_CYC)
        ) u_hold (
            .clk   (Clk),
            .rst   (Rst),
            .trig  (act_trig[i]),
            .clr   (act_clr[i]),
            .level (act_lvl[i])
        );
    end

    assign alarm_lvl = act_lvl[A_ALARM];

    // Beep phase: parked high while idle, toggles every BEEP_DIV held cycles.
    // Keyed off the held level, so retriggers do not restart the pattern.
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          beep_phase_q, beep_phase_d;

    always_comb begin
        beep_cnt_d   = beep_cnt_q;
        beep_phase_d = beep_phase_q;
        if (!alarm_lvl) begin
            beep_cnt_d   = '0;
            beep_phase_d = 1'b1;
        end else if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d   = '0;
            beep_phase_d = ~beep_phase_q;
        end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
        end
    end

    // Beep registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            beep_cnt_q   <= '0;
            beep_phase_q <= 1'b1;
        end else begin
            beep_cnt_q   <= beep_cnt_d;
            beep_phase_q <= beep_phase_d;
        end
    end

    // Display: valid codes load code and timer; the code clears on the edge the timer hits zero
    logic [2:0]    code_q, code_d;
    logic [DW-1:0] tmr_q, tmr_d;

    always_comb begin
        code_d = code_q;
        tmr_d  = tmr_q;
        if (disp_valid(display)) begin
            code_d = display;
            tmr_d  = DW'(DISP_CYC);
        end else begin
            if (tmr_q != '0) begin
                tmr_d = tmr_q - DW'(1);
            end
            if (tmr_d == '0) begin
                code_d = D_NONE;
            end
        end
    end

    // Display registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            code_q <= D_NONE;
            tmr_q  <= '0;
        end else begin
            code_q <= code_d;
            tmr_q  <= tmr_d;
        end
    end

    assign fdoor_o   = act_lvl[A_FDOOR];
    assign rdoor_o   = act_lvl[A_RDOOR];
    assign winbuzz_o = act_lvl[A_WIN];
    assign heater_o  = act_lvl[A_HEAT];
    assign cooler_o  = act_lvl[A_COOL];
    assign alarm_o   = alarm_lvl & beep_phase_q;
    // A live fire alarm owns the display; the code register keeps ageing underneath
    assign disp_o    = alarm_lvl ? D_FIRE : code_q;

endmodule

// File: tb/tb_actuator_hold.sv
module tb_actuator_hold;

    localparam int HOLD = 10;
    localparam int DISP = 20;
    localparam int BEEP = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [5:0] act = '0;    // {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler}
    logic [2:0] display = '0;
    logic fdoor_o, rdoor_o, winbuzz_o, heater_o, cooler_o, alarm_o;
    logic [2:0] disp_o;

    always #5 Clk = ~Clk;

    actuator_hold #(
        .HOLD_CYC (HOLD),
        .DISP_CYC (DISP),
        .BEEP_DIV (BEEP)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .fdoor     (act[5]),
        .rdoor     (act[4]),
        .alarmbuzz (act[3]),
        .winbuzz   (act[2]),
        .heater    (act[1]),
        .cooler    (act[0]),
        .display   (display),
        .fdoor_o   (fdoor_o),
        .rdoor_o   (rdoor_o),
        .winbuzz_o (winbuzz_o),
        .heater_o  (heater_o),
        .cooler_o  (cooler_o),
        .alarm_o   (alarm_o),
        .disp_o    (disp_o)
    );

    wire [8:0] obs = {fdoor_o, rdoor_o, winbuzz_o, heater_o, cooler_o, alarm_o, disp_o};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel remembers when it was last triggered; a hold is
    // "alive" until killed by reset or interlock, and lasts HOLD cycles from that time.
    int         cyc = 0;
    int         last [6];
    bit         alive [6];
    int         hstart = 0;
    int         dlast = 0;
    bit         dalive = 0;
    logic [2:0] dcode = '0;

    function automatic bit lvl(input int c);
        return alive[c] && ((cyc - last[c]) < HOLD);
    endfunction

    function automatic void load(input int c);
        alive[c] = 1'b1;
        last[c]  = cyc;
    endfunction

    function automatic void model_edge();
        bit prev_alarm;
        prev_alarm = lvl(3);
        cyc++;
        if (Rst) begin
            for (int c = 0; c < 6; c++) alive[c] = 1'b0;
            dalive = 1'b0;
        end else begin
            if (act[5]) load(5);
            if (act[4]) load(4);
            if (act[3]) load(3);
            if (act[2]) load(2);
            if (act[0]) alive[1] = 1'b0; else if (act[1]) load(1);
            if (act[1]) alive[0] = 1'b0; else if (act[0]) load(0);
            if (act[3] && !prev_alarm) hstart = cyc;
            if (display >= 3'd1 && display <= 3'd6) begin
                dalive = 1'b1;
                dlast  = cyc;
                dcode  = display;
            end
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        logic       a;
        logic [2:0] d;
        a = lvl(3) && ((((cyc - hstart) / BEEP) % 2) == 0);
        if (lvl(3))                                 d = 3'd3;
        else if (dalive && ((cyc - dlast) < DISP))  d = dcode;
        else                                        d = 3'd0;
        return {lvl(5), lvl(4), lvl(2), lvl(1), lvl(0), a, d};
    endfunction

    // Advance one clock: model sees the same inputs as the DUT edge, sample 1 time unit later
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; act = '1; display = 3'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: cycle %0d got %b expected %b", cyc, obs, 9'b0);
            end
            n_checks++;
            if (alarm_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_alarm: cycle %0d got %b expected 0", cyc, alarm_o);
            end
        end
        Rst = 1'b0; act = '0; display = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset: cycle %0d got %b expected %b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_single_pulse();
        logic e;
        act = 6'b100000;
        step();
        act = '0;
        n_checks++;
        if (fdoor_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse k=1: got %b expected 1", fdoor_o);
        end
        for (int k = 2; k <= 13; k++) begin
            step();
            e = (k <= HOLD);
            n_checks++;
            if (fdoor_o !== e) begin
                n_fail++;
                $display("FAIL single_pulse k=%0d: got %b expected %b", k, fdoor_o, e);
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_pulse_model: cycle %0d got %b expected %b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_polling();
        logic e;
        for (int i = 0; i < 40; i++) begin
            act = (i % 5 == 0) ? 6'b010000 : 6'b000000;
            step();
            n_checks++;
            if (rdoor_o !== 1'b1) begin
                n_fail++;
                $display("FAIL polling_gap i=%0d: got %b expected 1", i, rdoor_o);
            end
        end
        act = '0;
        // last pulse at i=35; k counts outputs since that pulse, k=5 was i=39
        for (int k = 6; k <= 13; k++) begin
            step();
            e = (k <= HOLD);
            n_checks++;
            if (rdoor_o !== e) begin
                n_fail++;
                $display("FAIL polling_tail k=%0d: got %b expected %b", k, rdoor_o, e);
            end
        end
    endtask

    task automatic test_interlock();
        logic eh, ec;
        for (int i = 0; i <= 25; i++) begin
            act = '0;
            if (i == 0 || i == 17) act[1] = 1'b1;
            if (i == 3)            act[0] = 1'b1;
            if (i == 20)           act[1:0] = 2'b11;
            step();
            eh = (i <= 2) || (i >= 17 && i <= 19);
            ec = (i >= 3 && i <= 12);
            n_checks++;
            if (heater_o !== eh || cooler_o !== ec) begin
                n_fail++;
                $display("FAIL interlock i=%0d: got h=%b c=%b expected h=%b c=%b", i, heater_o, cooler_o, eh, ec);
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL interlock_model: cycle %0d got %b expected %b", cyc, obs, exp_vec());
            end
        end
        act = '0;
    endtask

    task automatic test_alarm();
        logic       ea;
        logic [2:0] ed;
        for (int i = 0; i <= 30; i++) begin
            act = (i == 0 || i == 5 || i == 10) ? 6'b001000 : 6'b000000;
            display = (i == 0 || i == 5) ? 3'd3 : (i == 7) ? 3'd4 : 3'd0;
            step();
            ea = (i <= 19) && (((i / 4) % 2) == 0);
            ed = (i <= 19) ? 3'd3 : (i <= 26) ? 3'd4 : 3'd0;
            n_checks++;
            if (alarm_o !== ea) begin
                n_fail++;
                $display("FAIL alarm_beep i=%0d: got %b expected %b", i, alarm_o, ea);
            end
            n_checks++;
            if (disp_o !== ed) begin
                n_fail++;
                $display("FAIL alarm_disp i=%0d: got %0d expected %0d", i, disp_o, ed);
            end
        end
        act = '0; display = '0;
    endtask

    task automatic test_invalid_code();
        logic [2:0] ed;
        for (int i = 0; i <= 23; i++) begin
            display = (i == 0) ? 3'd2 : (i <= 5) ? 3'd7 : 3'd0;
            step();
            ed = (i <= 19) ? 3'd2 : 3'd0;
            n_checks++;
            if (disp_o !== ed) begin
                n_fail++;
                $display("FAIL invalid_code i=%0d: got %0d expected %0d", i, disp_o, ed);
            end
        end
        display = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 6; b++) act[b] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) act[1:0] = 2'b11;
            display = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            step();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d got %b expected %b", cyc, obs, exp_vec());
            end
            n_checks++;
            if (heater_o === 1'b1 && cooler_o === 1'b1) begin
                n_fail++;
                $display("FAIL random_interlock: cycle %0d got h=1 c=1 expected not both", cyc);
            end
        end
        Rst = 1'b0; act = '0; display = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pulse();
        test_polling();
        test_interlock();
        test_alarm();
        test_invalid_code();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
